// File: rtl/ternary_pkg.sv
// Shared constants and state encodings for the ternary matrix-vector core
// and its output collector.
package ternary_pkg;

  localparam int unsigned BitWidth = 8;
  localparam int unsigned OUT_LEN  = 7;
  localparam int unsigned IdxW     = 3;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_stat_e;

  typedef enum logic {
    FILL,
    DROP
  } fill_state_e;

endpackage

// File: rtl/ternary_requant.sv
// Combinational requantizer: rounding arithmetic right shift, saturation to
// the signed output byte range, then optional ReLU.
module ternary_requant
  import ternary_pkg::*;
(
  input  logic signed [BitWidth-1:0] i_data,
  input  logic        [2:0]          i_shift,
  input  logic                       i_relu,
  output logic signed [BitWidth-1:0] o_data
);

  // Two guard bits keep the rounding add free of overflow.
  localparam int unsigned ExtW = BitWidth + 2;
  localparam logic signed [ExtW-1:0] SatMax = ExtW'((2 ** (BitWidth - 1)) - 1);
  localparam logic signed [ExtW-1:0] SatMin = ~SatMax;

  logic signed [ExtW-1:0] w_ext;
  logic signed [ExtW-1:0] w_half;
  logic signed [ExtW-1:0] w_rnd;
  logic signed [ExtW-1:0] w_shf;

  always_comb begin
    w_ext  = ExtW'(i_data);
    w_half = (i_shift != 3'd0) ? (ExtW'(1) << (i_shift - 3'd1)) : '0;
    w_rnd  = w_ext + w_half;
    w_shf  = w_rnd >>> i_shift;
    if (w_shf > SatMax) begin
      o_data = SatMax[BitWidth-1:0];
    end else if (w_shf < SatMin) begin
      o_data = SatMin[BitWidth-1:0];
    end else begin
      o_data = w_shf[BitWidth-1:0];
    end
    if (i_relu && o_data[BitWidth-1]) begin
      o_data = '0;
    end
  end

endmodule

// File: rtl/ternary_out_collector.sv
// Collects requantized row results into a two-bank ping-pong buffer and
// drains complete vectors as a valid/ready byte stream with a last marker.
module ternary_out_collector
  import ternary_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [2:0]          in_row,
  input  logic [BitWidth-1:0] in_data,
  input  logic [2:0]          cfg_shift,
  input  logic                cfg_relu,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BitWidth-1:0] out_data,
  output logic                out_last,
  output logic                overflow,
  output logic                seq_err
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(OUT_LEN - 1);

  logic [BitWidth-1:0] r_bank [2][OUT_LEN];
  bank_stat_e          r_stat [2];
  bank_stat_e          w_stat_drn [2];
  bank_stat_e          w_stat_nxt [2];
  fill_state_e         r_fstate, w_fstate_nxt;
  logic                r_fill_ptr, w_fill_ptr_nxt;
  logic                r_rd_ptr, w_rd_ptr_nxt;
  logic [IdxW-1:0]     r_wr_idx, w_wr_idx_nxt;
  logic [IdxW-1:0]     r_rd_idx, w_rd_idx_nxt;
  logic                r_out_valid, r_out_last, r_overflow, r_seq_err;
  logic [BitWidth-1:0] r_out_data;
  logic [BitWidth-1:0] w_rq;
  logic                w_hs, w_out_valid_nxt;
  logic                w_we, w_we_bank, w_last_wr;
  logic [IdxW-1:0]     w_we_idx;
  logic                w_ovf_set, w_seq_set;
  logic                w_any_empty, w_empty_bank;

  ternary_requant u_requant (
    .i_data  (in_data),
    .i_shift (cfg_shift),
    .i_relu  (cfg_relu),
    .o_data  (w_rq)
  );

  // Drain side: advance the read index and free the bank on its last byte.
  always_comb begin
    w_hs         = r_out_valid & out_ready;
    w_stat_drn   = r_stat;
    w_rd_idx_nxt = r_rd_idx;
    if (w_hs) begin
      if (r_rd_idx == LastIdx) begin
        w_stat_drn[r_rd_ptr] = EMPTY;
        w_rd_idx_nxt         = '0;
      end else begin
        w_stat_drn[r_rd_ptr] = DRAINING;
        w_rd_idx_nxt         = r_rd_idx + IdxW'(1);
      end
    end
  end

  // A bank freed by this cycle's drain already counts as empty.
  assign w_empty_bank = (w_stat_drn[~r_fill_ptr] == EMPTY) ? ~r_fill_ptr : r_fill_ptr;
  assign w_any_empty  = (w_stat_drn[0] == EMPTY) || (w_stat_drn[1] == EMPTY);

  // Fill FSM outputs: which beat is written where, and flag events.
  always_comb begin
    w_we      = 1'b0;
    w_we_bank = r_fill_ptr;
    w_we_idx  = r_wr_idx;
    w_seq_set = 1'b0;
    w_ovf_set = 1'b0;
    if (in_valid) begin
      unique case (r_fstate)
        FILL: begin
          if (in_row == r_wr_idx) begin
            w_we = 1'b1;
          end else if (in_row == 3'd0) begin
            w_we      = 1'b1;
            w_we_idx  = '0;
            w_seq_set = 1'b1;
          end else begin
            w_seq_set = 1'b1;
          end
        end
        DROP: begin
          if (in_row == 3'd0) begin
            if (w_any_empty) begin
              w_we      = 1'b1;
              w_we_bank = w_empty_bank;
              w_we_idx  = '0;
            end else begin
              w_ovf_set = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    w_last_wr = w_we && (w_we_idx == LastIdx);
  end

  // Fill FSM next state, bank status and fill pointer.
  always_comb begin
    w_fstate_nxt   = r_fstate;
    w_fill_ptr_nxt = r_fill_ptr;
    w_wr_idx_nxt   = r_wr_idx;
    w_stat_nxt     = w_stat_drn;
    if (w_we) begin
      w_fstate_nxt   = FILL;
      w_fill_ptr_nxt = w_we_bank;
      if (w_last_wr) begin
        w_stat_nxt[w_we_bank] = FULL;
        w_wr_idx_nxt          = '0;
        if (w_stat_drn[~w_we_bank] == EMPTY) begin
          w_fill_ptr_nxt = ~w_we_bank;
        end else begin
          w_fstate_nxt = DROP;
        end
      end else begin
        w_stat_nxt[w_we_bank] = FILLING;
        w_wr_idx_nxt          = w_we_idx + IdxW'(1);
      end
    end
  end

  // Read pointer hops to the other bank once it is full and ours is idle.
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    if (!(w_stat_nxt[r_rd_ptr] inside {FULL, DRAINING}) && (w_stat_nxt[~r_rd_ptr] == FULL)) begin
      w_rd_ptr_nxt = ~r_rd_ptr;
    end
    w_out_valid_nxt = w_stat_nxt[w_rd_ptr_nxt] inside {FULL, DRAINING};
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_bank[w_we_bank][w_we_idx] <= w_rq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat      <= '{EMPTY, EMPTY};
      r_fstate    <= FILL;
      r_fill_ptr  <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_overflow  <= 1'b0;
      r_seq_err   <= 1'b0;
    end else begin
      r_stat      <= w_stat_nxt;
      r_fstate    <= w_fstate_nxt;
      r_fill_ptr  <= w_fill_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_wr_idx    <= w_wr_idx_nxt;
      r_rd_idx    <= w_rd_idx_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_valid_nxt ? r_bank[w_rd_ptr_nxt][w_rd_idx_nxt] : '0;
      r_out_last  <= w_out_valid_nxt && (w_rd_idx_nxt == LastIdx);
      r_overflow  <= r_overflow | w_ovf_set;
      r_seq_err   <= r_seq_err | w_seq_set;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign overflow  = r_overflow;
  assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_ternary_out_collector.sv
// Scoreboard bench for ternary_out_collector: expected bytes are queued as
// beats are driven and popped as the output stream hands them over.
module tb_ternary_out_collector;

  localparam int NRow = 7;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_row;
  logic [7:0] in_data;
  logic [2:0] cfg_shift;
  logic       cfg_relu;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       overflow;
  logic       seq_err;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [8:0] sb_q[$];
  logic [8:0] m_exp;
  logic [8:0] hold_d;
  logic       hold_v  = 1'b0;
  bit         rnd_done;

  ternary_out_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_row    (in_row),
    .in_data   (in_data),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .overflow  (overflow),
    .seq_err   (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: hold stability plus scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        n_total++;
        if (out_valid !== 1'b1 || {out_last, out_data} !== hold_d)
          $display("FAIL hold_stable: got valid=%b last=%b data=%0d, want valid=1 last=%b data=%0d",
                   out_valid, out_last, out_data, hold_d[8], hold_d[7:0]);
        else n_pass++;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_total++;
        if (sb_q.size() == 0) begin
          $display("FAIL unexpected_byte: got data=%0d last=%b, want no byte", out_data, out_last);
        end else begin
          m_exp = sb_q.pop_front();
          if ({out_last, out_data} !== m_exp)
            $display("FAIL out_byte: got data=%0d last=%b, want data=%0d last=%b",
                     $signed(out_data), out_last, $signed(m_exp[7:0]), m_exp[8]);
          else n_pass++;
        end
      end
      hold_v = (out_valid === 1'b1) && (out_ready !== 1'b1);
      hold_d = {out_last, out_data};
    end
  end

  function automatic logic [7:0] ref_rq(input int d, input int sh, input bit rl);
    int v;
    v = d;
    if (sh > 0) v = v + (1 << (sh - 1));
    v = v >>> sh;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    if (rl && v < 0) v = 0;
    return 8'(v);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input int row, input int d, input int sh, input bit rl);
    in_valid  = 1'b1;
    in_row    = 3'(row);
    in_data   = 8'(d);
    cfg_shift = 3'(sh);
    cfg_relu  = rl;
    tick(1);
    in_valid  = 1'b0;
  endtask

  // One full vector of random data/config at core cadence (gap after last row).
  task automatic send_rand_vec(input bit push);
    int d [NRow];
    int sh[NRow];
    bit rl[NRow];
    for (int r = 0; r < NRow; r++) begin
      d[r]  = int'($urandom_range(0, 255)) - 128;
      sh[r] = int'($urandom_range(0, 7));
      rl[r] = ($urandom_range(0, 3) == 0);
      if (push) sb_q.push_back({r == NRow - 1, ref_rq(d[r], sh[r], rl[r])});
    end
    for (int r = 0; r < NRow; r++) send_beat(r, d[r], sh[r], rl[r]);
    tick(1);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 1000) begin
      tick(1);
      guard++;
    end
    n_total++;
    if (sb_q.size() != 0)
      $display("FAIL drain_timeout: got %0d bytes pending, want 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== 8'd0) $display("FAIL rst_out_data: got %0d want 0", out_data); else n_pass++;
    n_total++; if (out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", out_last); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow); else n_pass++;
    n_total++; if (seq_err !== 1'b0) $display("FAIL rst_seq_err: got %b want 0", seq_err); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_basic();
    int v[NRow] = '{10, -20, 30, -40, 50, -60, 70};
    out_ready = 1'b1;
    for (int r = 0; r < NRow; r++) sb_q.push_back({r == NRow - 1, 8'(v[r])});
    for (int r = 0; r < NRow - 1; r++) send_beat(r, v[r], 0, 1'b0);
    n_total++; if (out_valid !== 1'b0) $display("FAIL valid_early: got %b want 0", out_valid); else n_pass++;
    send_beat(NRow - 1, v[NRow - 1], 0, 1'b0);
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 8'd10)
      $display("FAIL valid_latency: got valid=%b data=%0d, want valid=1 data=10", out_valid, out_data);
    else n_pass++;
    tick(1);
    wait_drain();
  endtask

  task automatic test_requant();
    out_ready = 1'b1;
    sb_q.push_back({1'b0, 8'd64});
    sb_q.push_back({1'b0, 8'hFF});
    sb_q.push_back({1'b0, 8'd0});
    sb_q.push_back({1'b0, 8'hFF});
    sb_q.push_back({1'b0, 8'd25});
    sb_q.push_back({1'b0, 8'hE7});
    sb_q.push_back({1'b1, 8'd19});
    send_beat(0, 127, 1, 1'b0);
    send_beat(1, -3, 1, 1'b0);
    send_beat(2, -100, 0, 1'b1);
    send_beat(3, -128, 7, 1'b0);
    send_beat(4, 100, 2, 1'b0);
    send_beat(5, -101, 2, 1'b0);
    send_beat(6, 77, 2, 1'b0);
    tick(1);
    wait_drain();
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    n_total++; if (overflow !== 1'b0) $display("FAIL ovf_pre: got %b want 0", overflow); else n_pass++;
    send_rand_vec(1'b1);
    send_rand_vec(1'b1);
    send_rand_vec(1'b0);
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else n_pass++;
    n_total++; if (out_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", out_valid); else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 2 * NRow; i++) begin
      n_total++;
      if (out_valid !== 1'b1) $display("FAIL no_bubble: cycle %0d got valid=%b want 1", i, out_valid);
      else n_pass++;
      tick(1);
    end
    wait_drain();
  endtask

  task automatic test_seq_err();
    out_ready = 1'b1;
    n_total++; if (seq_err !== 1'b0) $display("FAIL seq_pre: got %b want 0", seq_err); else n_pass++;
    send_beat(0, 5, 0, 1'b0);
    send_beat(1, 6, 0, 1'b0);
    send_beat(2, 7, 0, 1'b0);
    send_rand_vec(1'b1);
    n_total++; if (seq_err !== 1'b1) $display("FAIL seq_set: got %b want 1", seq_err); else n_pass++;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send_rand_vec(1'b1);
    for (int r = 0; r < 4; r++) send_beat(r, r * 3 + 1, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== 8'd0) $display("FAIL mid_rst_data: got %0d want 0", out_data); else n_pass++;
    n_total++; if (out_last !== 1'b0) $display("FAIL mid_rst_last: got %b want 0", out_last); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL mid_rst_ovf: got %b want 0", overflow); else n_pass++;
    n_total++; if (seq_err !== 1'b0) $display("FAIL mid_rst_seq: got %b want 0", seq_err); else n_pass++;
    sb_q.delete();
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    send_rand_vec(1'b1);
    wait_drain();
  endtask

  task automatic test_random_ready();
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          int guard = 0;
          while (sb_q.size() > NRow && guard < 1000) begin
            tick(1);
            guard++;
          end
          if (guard >= 1000) begin
            n_total++;
            $display("FAIL rand_pace_timeout: got %0d bytes pending, want <= %0d", sb_q.size(), NRow);
          end
          send_rand_vec(1'b1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick(1);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    n_total++; if (overflow !== 1'b0) $display("FAIL rand_ovf: got %b want 0", overflow); else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_row    = 3'd0;
    in_data   = 8'd0;
    cfg_shift = 3'd0;
    cfg_relu  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_requant();
    test_overflow();
    test_seq_err();
    test_reset_mid();
    test_random_ready();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
